// File: rtl/rtc_pkg.sv
// Shared register map, bit positions and counter helper for the DS12887 emulation.
package rtc_pkg;

  localparam logic [7:0] RTC_SEC  = 8'h00;
  localparam logic [7:0] RTC_MIN  = 8'h02;
  localparam logic [7:0] RTC_HR   = 8'h04;
  localparam logic [7:0] RTC_REGA = 8'h0A;
  localparam logic [7:0] RTC_REGB = 8'h0B;
  localparam logic [7:0] RTC_REGC = 8'h0C;
  localparam logic [7:0] RTC_REGD = 8'h0D;

  localparam int REGA_UIP  = 7;
  localparam int REGB_SET  = 7;
  localparam int REGB_UIE  = 4;
  localparam int REGC_IRQF = 7;
  localparam int REGC_UF   = 4;
  localparam int REGD_VRT  = 7;

  typedef enum logic [1:0] {
    LD_SEC = 2'd0,
    LD_MIN = 2'd1,
    LD_HR  = 2'd2
  } ld_sel_t;

  typedef struct packed {
    logic       carry;
    logic [7:0] val;
  } cnt_step_t;

  // Only the exact top value wraps; out-of-range values just count up to 255->0.
  function automatic cnt_step_t cnt_step(input logic [7:0] v, input logic [7:0] top);
    cnt_step_t r;
    if (v == top) begin
      r.carry = 1'b1;
      r.val   = 8'h00;
    end else begin
      r.carry = 1'b0;
      r.val   = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_timebase.sv
// 1 s prescaler plus binary sec/min/hr counters; loads take effect next edge.
// Loads always accepted and override a same-cycle tick for that register.
module rtc_timebase
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       ld_vld,
  input  ld_sel_t    ld_sel,
  input  logic [7:0] ld_dat,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hr,
  output logic       tick,
  output logic       uip
);

  localparam int             PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] ps_q, ps_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  cnt_step_t     s_nx, m_nx, h_nx;
  logic          sec_cy, min_cy;

  always_comb begin
    uip  = (ps_q == PS_LAST);
    tick = uip && !hold;
    if (hold || uip) ps_d = '0;
    else             ps_d = ps_q + 1'b1;

    s_nx = cnt_step(sec_q, 8'd59);
    m_nx = cnt_step(min_q, 8'd59);
    h_nx = cnt_step(hr_q, 8'd23);

    // A CPU load of a register suppresses the carry out of that register.
    sec_cy = tick && s_nx.carry && !(ld_vld && ld_sel == LD_SEC);
    min_cy = sec_cy && m_nx.carry && !(ld_vld && ld_sel == LD_MIN);

    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (tick)   sec_d = s_nx.val;
    if (sec_cy) min_d = m_nx.val;
    if (min_cy) hr_d  = h_nx.val;

    if (ld_vld) begin
      case (ld_sel)
        LD_SEC:  sec_d = ld_dat;
        LD_MIN:  min_d = ld_dat;
        LD_HR:   hr_d  = ld_dat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q  <= '0;
      sec_q <= 8'h00;
      min_q <= 8'h00;
      hr_q  <= 8'h00;
    end else begin
      ps_q  <= ps_d;
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
    end
  end

  assign sec = sec_q;
  assign min = min_q;
  assign hr  = hr_q;

endmodule

// File: rtl/rtc_ds12887_slave.sv
// DS12887 bus responder: register file, time registers and A/B/C/D on the AD/AS bus.
// Reads drive ad combinationally; writes commit on wr_n rising; no wait states.
module rtc_ds12887_slave
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int ADDR_W   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire  [7:0] ad,
  input  logic       as,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       cs_n,
  output logic       irq_n
);

  localparam logic [ADDR_W-1:0] A_SEC  = ADDR_W'(RTC_SEC);
  localparam logic [ADDR_W-1:0] A_MIN  = ADDR_W'(RTC_MIN);
  localparam logic [ADDR_W-1:0] A_HR   = ADDR_W'(RTC_HR);
  localparam logic [ADDR_W-1:0] A_REGA = ADDR_W'(RTC_REGA);
  localparam logic [ADDR_W-1:0] A_REGB = ADDR_W'(RTC_REGB);
  localparam logic [ADDR_W-1:0] A_REGC = ADDR_W'(RTC_REGC);
  localparam logic [ADDR_W-1:0] A_REGD = ADDR_W'(RTC_REGD);

  logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rd_q, wr_q, cs_q;
  logic [6:0]        rega_q, rega_d;
  logic [7:0]        regb_q, regb_d, regc_q, regc_d;
  logic [7:0]        ram_q [2**ADDR_W];

  logic       wr_commit, rd_done, ram_we, ld_vld, ad_oe;
  ld_sel_t    ld_sel;
  logic [7:0] rdata, sec, min, hr;
  logic       tick, uip;

  rtc_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (regb_q[REGB_SET]),
    .ld_vld (ld_vld),
    .ld_sel (ld_sel),
    .ld_dat (wdata_q),
    .sec    (sec),
    .min    (min),
    .hr     (hr),
    .tick   (tick),
    .uip    (uip)
  );

  always_comb begin
    addr_lat_d = (as && !cs_n) ? ad[ADDR_W-1:0] : addr_lat_q;
    wdata_d    = (!wr_n && !cs_n) ? ad : wdata_q;
    waddr_d    = (!wr_n && !cs_n) ? addr_lat_q : waddr_q;
    raddr_d    = (!rd_n && !cs_n) ? addr_lat_q : raddr_q;
    // Strobe ends are qualified by the previous cycle's chip select, and the
    // commit uses captured data because the next address is already on ad.
    wr_commit  = !wr_q && wr_n && !cs_q;
    rd_done    = !rd_q && rd_n && !cs_q;
  end

  always_comb begin
    rega_d = rega_q;
    regb_d = regb_q;
    ram_we = 1'b0;
    ld_vld = 1'b0;
    ld_sel = LD_SEC;
    if (wr_commit) begin
      case (waddr_q)
        A_SEC:  begin ld_vld = 1'b1; ld_sel = LD_SEC; end
        A_MIN:  begin ld_vld = 1'b1; ld_sel = LD_MIN; end
        A_HR:   begin ld_vld = 1'b1; ld_sel = LD_HR;  end
        A_REGA: rega_d = wdata_q[6:0];
        A_REGB: regb_d = wdata_q;
        A_REGC, A_REGD: ;
        default: ram_we = 1'b1;
      endcase
    end

    // Tick flags are applied after the read-clear so they survive a collision.
    regc_d = regc_q;
    if (rd_done && raddr_q == A_REGC) regc_d = 8'h00;
    if (tick) begin
      regc_d[REGC_UF] = 1'b1;
      if (regb_q[REGB_UIE]) regc_d[REGC_IRQF] = 1'b1;
    end
  end

  always_comb begin
    rdata = ram_q[addr_lat_q];
    case (addr_lat_q)
      A_SEC:  rdata = sec;
      A_MIN:  rdata = min;
      A_HR:   rdata = hr;
      A_REGA: begin
        rdata           = {1'b0, rega_q};
        rdata[REGA_UIP] = uip;
      end
      A_REGB: rdata = regb_q;
      A_REGC: rdata = regc_q;
      A_REGD: begin
        rdata           = 8'h00;
        rdata[REGD_VRT] = 1'b1;
      end
      default: ;
    endcase
    ad_oe = rst_n && !rd_n && !cs_n;
  end

  assign ad    = ad_oe ? rdata : 8'bzzzz_zzzz;
  assign irq_n = !regc_q[REGC_IRQF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lat_q <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      wdata_q    <= 8'h00;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      cs_q       <= 1'b1;
      rega_q     <= 7'h20;
      regb_q     <= 8'h06;
      regc_q     <= 8'h00;
    end else begin
      addr_lat_q <= addr_lat_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      cs_q       <= cs_n;
      rega_q     <= rega_d;
      regb_q     <= regb_d;
      regc_q     <= regc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[waddr_q] <= wdata_q;
  end

endmodule

// File: doc/rtc_ds12887_slave.md
Name: rtc_ds12887_slave

Overview:
- Bus-responder emulation of a DS12887 real-time clock on the multiplexed AD/AS/RD/WR/CS bus, for loop-back testing of the 68k RTC controller and for boards with no RTC fitted.
- Contains a 128-byte register file, binary seconds/minutes/hours timekeeping and the registers A/B/C/D subset.
- Runs in the same clock domain as the bus initiator, so no synchronizers are used.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per 1-second tick; minimum 2; benches use a small value.
- ADDR_W, 7: register-file address width, giving 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ad  inout  8  multiplexed address/data bus; driven only during a read.
- as  in  1  address strobe, active high; the address latch is transparent while as=1.
- rd_n  in  1  read strobe, active low.
- wr_n  in  1  write strobe, active low.
- cs_n  in  1  chip select, active low.
- irq_n  out  1  interrupt; low while register C bit7 (IRQF) is set.

Behaviour:
- Reset (async, rst_n=0):
  - addr_lat=0, wdata=0, waddr=0, prescaler=0.
  - seconds=minutes=hours=0; register A=0x20; register B=0x06 (binary, 24h); register C=0x00.
  - RAM bytes are not reset.
  - ad is released (hi-Z); irq_n=1.
  - A reset in the middle of an access aborts it; no write is committed.
- Address latch:
  - Each clk edge where as=1 and cs_n=0: addr_lat <= ad[ADDR_W-1:0].
  - ad[7] is ignored.
- Read:
  - ad = rdata combinationally while rd_n=0 and cs_n=0; otherwise hi-Z.
  - rdata is a combinational decode of addr_lat:
    - 0x00 seconds, 0x02 minutes, 0x04 hours.
    - 0x0A register A, with bit7 UIP=1 during the last cycle before a tick.
    - 0x0B register B.
    - 0x0C register C.
    - 0x0D returns 0x80 (VRT).
    - All other addresses read the RAM.
  - Data is valid in the same cycle rd_n falls, so the initiator can sample on the next edge.
- Read side effect: on a rd_n rising edge (rd_q=0, rd_n=1) with the previous cycle's cs_n=0 and the read address 0x0C, register C is cleared.
- Write:
  - Each edge where wr_n=0 and cs_n=0: wdata <= ad and waddr <= addr_lat.
  - Commit on the wr_n rising edge (wr_q=0, wr_n=1), qualified by the previous cycle's cs_n=0.
  - The commit must not use the live ad/addr_lat, because the initiator drives the next address in that same cycle.
- Write targets:
  - 0x00/0x02/0x04 load the time counters.
  - 0x0A stores bits[6:0] only (UIP is read-only).
  - 0x0B stores all bits.
  - 0x0C and 0x0D are read-only and writes are ignored.
  - Any other address writes RAM.
- Back-to-back accesses: a word access (two strobes under one cs_n) must yield two independent reads or commits, without extra idle cycles.
- Timekeeping:
  - The prescaler counts 0..TICK_DIV-1; a tick fires at wrap.
  - On a tick with register B bit7 (SET)=0:
    - seconds increments; 59 wraps to 0 and carries to minutes.
    - minutes 59 wraps to 0 and carries to hours.
    - hours 23 wraps to 0.
    - Register C bit4 (UF) is set; bit7 (IRQF) is set if register B bit4 (UIE)=1.
  - While SET=1: the counters hold and the prescaler is held at 0.
- Simultaneous events:
  - A CPU commit to a time register in the same cycle as a tick: the CPU value wins, with no carry from that register.
  - A read-clear of register C in the same cycle as a tick: the tick's flags win, so they remain set.
- Out-of-range time writes (e.g. seconds=75) are stored as written; a later tick increments the value without wrapping until it reaches 255→0; no wrap logic is applied to such values.

Decomposition:
- Package rtc_pkg holds:
  - Register addresses: RTC_SEC=0x00, RTC_MIN=0x02, RTC_HR=0x04, RTC_REGA=0x0A, RTC_REGB=0x0B, RTC_REGC=0x0C, RTC_REGD=0x0D.
  - Register bit positions: SET, UIE, UF, IRQF, UIP, VRT.
- Sub-module rtc_timebase holds the prescaler plus the sec/min/hr counters, with a load port and a tick output. The bus decode and register file stay in the top level.

Test Plan:
- Byte write then read: AS latch 0x20, write 0x5A via wr_n low for 1 cycle; then latch 0x20 and assert rd_n → ad=0x5A on the cycle rd_n is low.
- Word write (addr 0x10 then 0x11 under one cs_n, data 0x12/0x34) → reads return 0x12 from 0x10 and 0x34 from 0x11. Commits must not land on the second address.
- Rollover, TICK_DIV=4: write sec=59, min=59, hr=23, then wait 4 cycles → 0/0/0; register C = 0x10; irq_n stays 1.
- Interrupt and clear:
  - With register B=0x16, one tick → register C=0x90 and irq_n=0.
  - Reading 0x0C returns 0x90; after rd_n rises, register C=0x00 and irq_n=1.
- SET hold and write/tick collision:
  - With register B=0x86, 10 ticks' worth of cycles → seconds unchanged.
  - With SET cleared, a write of seconds=30 on the tick cycle → seconds reads 30.
- Reset mid-write: rst_n low while wr_n=0 with data 0x77 to RAM address 0x30 → the address keeps its old value; seconds=0; ad is hi-Z.
